// File: rtl/enc_framer_pkg.sv
// ---------------------------------------------------------------------------
// enc_framer_pkg : shared K-symbol codes and state encoding for the tx framer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package enc_framer_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;  // idle comma
   localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
   localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
   localparam logic [7:0] K23_7 = 8'hF7;  // underrun pad
   localparam logic [7:0] K30_7 = 8'hFE;  // error delimiter

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SOF   = 3'd1,
      DATA  = 3'd2,
      CHK   = 3'd3,
      EOF   = 3'd4,
      ERR   = 3'd5,
      DRAIN = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/framer_stats.sv
// ---------------------------------------------------------------------------
// framer_stats : wrapping packet counter and saturating error counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module framer_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_pkt_inc,
   input  logic        i_err_inc,
   output logic [15:0] o_pkt_cnt,
   output logic [7:0]  o_err_cnt
);

   logic [15:0] r_pkt_cnt;
   logic [7:0]  r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt <= 16'd0;
         r_err_cnt <= 8'd0;
      end else begin
         if (i_pkt_inc) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
         if (i_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign o_pkt_cnt = r_pkt_cnt;
   assign o_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: rtl/enc_tx_framer.sv
// ---------------------------------------------------------------------------
// enc_tx_framer : byte-stream to 8B/10B symbol framer (one symbol per clock)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enc_tx_framer
   import enc_framer_pkg::*;
#(
   parameter int IFG     = 4,
   parameter int MAX_LEN = 1518,
   parameter int CHK_EN  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  enc_data,
   output logic        enc_k,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  err_cnt,
   output logic        in_frame
);

   localparam logic [7:0]  c_IFG = 8'(IFG);
   localparam logic [15:0] c_MAX = 16'(MAX_LEN);

   state_t      r_state;
   logic [7:0]  r_gap;
   logic [15:0] r_cnt;
   logic [7:0]  r_chk;
   logic [7:0]  r_data;
   logic        r_k;
   logic        r_in_frame;

   state_t      w_state_nxt;
   logic [7:0]  w_gap_nxt;
   logic [15:0] w_cnt_nxt;
   logic [7:0]  w_chk_nxt;
   logic [7:0]  w_sym;
   logic        w_k;
   logic        w_frame;
   logic        w_pkt_inc;
   logic        w_err_inc;
   logic [7:0]  w_gap_inc;
   logic [15:0] w_cnt_inc;

   // Gap counts idles including the current one, so SOF follows exactly IFG idles.
   assign w_gap_inc = (r_gap == c_IFG) ? r_gap : r_gap + 8'd1;
   assign w_cnt_inc = r_cnt + 16'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_cnt_nxt   = r_cnt;
      w_chk_nxt   = r_chk;
      w_sym       = K28_5;
      w_k         = 1'b1;
      w_frame     = 1'b0;
      w_pkt_inc   = 1'b0;
      w_err_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            w_gap_nxt = w_gap_inc;
            if ((w_gap_inc == c_IFG) && s_valid) begin
               w_state_nxt = SOF;
            end
         end
         SOF: begin
            w_sym       = K27_7;
            w_frame     = 1'b1;
            w_chk_nxt   = 8'd0;
            w_cnt_nxt   = 16'd0;
            w_state_nxt = DATA;
         end
         DATA: begin
            w_frame = 1'b1;
            if (s_valid) begin
               w_sym     = s_data;
               w_k       = 1'b0;
               w_chk_nxt = r_chk ^ s_data;
               w_cnt_nxt = w_cnt_inc;
               // s_last on the final allowed byte still closes a legal packet.
               if (s_last) begin
                  w_state_nxt = (CHK_EN != 0) ? CHK : EOF;
               end else if (w_cnt_inc == c_MAX) begin
                  w_state_nxt = ERR;
               end
            end else begin
               w_sym = K23_7;
            end
         end
         CHK: begin
            w_sym       = r_chk;
            w_k         = 1'b0;
            w_frame     = 1'b1;
            w_state_nxt = EOF;
         end
         EOF: begin
            w_sym       = K29_7;
            w_frame     = 1'b1;
            w_pkt_inc   = 1'b1;
            w_gap_nxt   = 8'd0;
            w_state_nxt = IDLE;
         end
         ERR: begin
            w_sym       = K30_7;
            w_frame     = 1'b1;
            w_err_inc   = 1'b1;
            w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (s_valid && s_last) begin
               w_gap_nxt   = 8'd0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gap      <= 8'd0;
         r_cnt      <= 16'd0;
         r_chk      <= 8'd0;
         r_data     <= K28_5;
         r_k        <= 1'b1;
         r_in_frame <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap      <= w_gap_nxt;
         r_cnt      <= w_cnt_nxt;
         r_chk      <= w_chk_nxt;
         r_data     <= w_sym;
         r_k        <= w_k;
         r_in_frame <= w_frame;
      end
   end

   assign s_ready  = (r_state == DATA) || (r_state == DRAIN);
   assign enc_data = r_data;
   assign enc_k    = r_k;
   assign in_frame = r_in_frame;

   framer_stats u_stats (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pkt_inc (w_pkt_inc),
      .i_err_inc (w_err_inc),
      .o_pkt_cnt (pkt_cnt),
      .o_err_cnt (err_cnt)
   );

endmodule

`default_nettype wire
